// File: rtl/regfile_reader_pkg.sv
// Shared types for the RegFile read-back engine: FSM state encoding,
// default widths and the {addr, data} word carried on the output stream.
package regfile_reader_pkg;

  localparam int RR_DATA_W = 32;
  localparam int RR_ADDR_W = 5;

  typedef enum logic [2:0] {
    RR_IDLE,
    RR_FETCH,
    RR_EMIT_A,
    RR_EMIT_B,
    RR_DONE
  } rr_state_e;

  typedef struct packed {
    logic [RR_ADDR_W-1:0] addr;
    logic [RR_DATA_W-1:0] data;
  } rr_word_t;

endpackage

// File: rtl/regfile_reader.sv
// Sweeps an inclusive, wrapping register range through the two RegFile read
// ports (two registers per fetch) and streams {addr, data} words over valid/ready.
module regfile_reader
  import regfile_reader_pkg::*;
#(
  parameter int DATA_W = RR_DATA_W,
  parameter int ADDR_W = RR_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] FR_RAddr_1,
  output logic [ADDR_W-1:0] FR_RAddr_2,
  input  logic [DATA_W-1:0] FR_Rdata_1,
  input  logic [DATA_W-1:0] FR_Rdata_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] REM_TWO = (ADDR_W+1)'(2);

  rr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic [ADDR_W-1:0] raddr1_q, raddr1_d;
  logic [ADDR_W-1:0] raddr2_q, raddr2_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rem_d       = rem_q;
    buf_d[0]    = buf_q[0];
    buf_d[1]    = buf_q[1];
    raddr1_d    = raddr1_q;
    raddr2_d    = raddr2_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      RR_IDLE: begin
        if (start) begin
          // Remaining count is one wider than an address so a full sweep fits.
          cur_d    = first_addr;
          rem_d    = {1'b0, last_addr - first_addr} + REM_ONE;
          raddr1_d = first_addr;
          raddr2_d = first_addr + ADDR_W'(1);
          busy_d   = 1'b1;
          state_d  = RR_FETCH;
        end
      end

      RR_FETCH: begin
        buf_d[0]    = FR_Rdata_1;
        buf_d[1]    = FR_Rdata_2;
        out_valid_d = 1'b1;
        out_addr_d  = cur_q;
        state_d     = RR_EMIT_A;
      end

      RR_EMIT_A: begin
        if (out_ready) begin
          if (rem_q == REM_ONE) begin
            // Odd tail: the port-2 word of this pair is dropped.
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = RR_DONE;
          end else begin
            out_addr_d = cur_q + ADDR_W'(1);
            state_d    = RR_EMIT_B;
          end
        end
      end

      RR_EMIT_B: begin
        if (out_ready) begin
          rem_d       = rem_q - REM_TWO;
          cur_d       = cur_q + ADDR_W'(2);
          out_valid_d = 1'b0;
          if (rem_q == REM_TWO) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = RR_DONE;
          end else begin
            raddr1_d = cur_q + ADDR_W'(2);
            raddr2_d = cur_q + ADDR_W'(3);
            state_d  = RR_FETCH;
          end
        end
      end

      RR_DONE: begin
        state_d = RR_IDLE;
      end

      default: begin
        state_d = RR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RR_IDLE;
      cur_q       <= '0;
      rem_q       <= '0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      raddr1_q    <= '0;
      raddr2_q    <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
      raddr1_q    <= raddr1_d;
      raddr2_q    <= raddr2_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The word on the bus always comes straight out of the pair buffer.
  assign out_data   = (state_q == RR_EMIT_B) ? buf_q[1] : buf_q[0];
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign FR_RAddr_1 = raddr1_q;
  assign FR_RAddr_2 = raddr2_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
